sdram_burst_sched: RTL and testbench

SDRAM_BURST_SCHED -- requirements
Module: sdram_burst_sched

---
 rtl/sdram_pkg.sv | 35 +++
 rtl/sdram_ptr.sv | 34 +++
 rtl/sdram_burst_sched.sv | 196 +++++++++++++++++++
 tb/tb_sdram_burst_sched.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared definitions for the SDRAM burst scheduler: default
//               geometry, scheduler FSM state encoding and the SDRAM command
//               encoding used by the downstream SDRAM interface.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // Default geometry: full-page burst of 512 words, 4 banks of 8192 rows
    localparam int unsigned C_BURST_LEN = 512;
    localparam int unsigned C_ROW_W     = 13;
    localparam int unsigned C_BANK_W    = 2;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_WR_BURST = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_BURST = 3'd4
    } sched_state_t;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] C_CMD_LMR       = 4'b0000;
    localparam logic [3:0] C_CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] C_CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] C_CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] C_CMD_WRITE     = 4'b0100;
    localparam logic [3:0] C_CMD_READ      = 4'b0101;
    localparam logic [3:0] C_CMD_NOP       = 4'b0111;

endpackage : sdram_pkg
`default_nettype wire

// File: rtl/sdram_ptr.sv
`default_nettype none
// ============================================================================
// Module      : sdram_ptr
// Description : Burst pointer {wrap, bank, row}. A plain binary increment
//               rolls the row into the bank and the last bank into the wrap
//               bit, which is what distinguishes full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_ptr #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    output logic [ADDR_W:0]   o_ptr
);

    localparam logic [ADDR_W:0] C_ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] r_ptr;

    // Advance by one burst slot when a burst completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + C_ONE;
        end
    end

    assign o_ptr = r_ptr;

endmodule : sdram_ptr
`default_nettype wire

// File: rtl/sdram_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : sdram_burst_sched
// Description : Schedules full-page write and read bursts between a write
//               client, a read client and an SDRAM interface, using the SDRAM
//               as a ring buffer of burst slots addressed by {bank,row}.
//               Optional macro SDRAM_SCHED_RR_EN: round-robin arbitration
//               between the two clients; default is fixed write priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_burst_sched
    import sdram_pkg::*;
#(
    parameter int unsigned BURST_LEN = C_BURST_LEN,
    parameter int unsigned ROW_W     = C_ROW_W,
    parameter int unsigned BANK_W    = C_BANK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cli_wr_req,
    input  logic               cli_rd_req,
    input  logic               wr_ack,
    input  logic               rd_ack,
    input  logic               rdata_vld,
    output logic               wr_req,
    output logic               rd_req,
    output logic [BANK_W-1:0]  bank,
    output logic [ROW_W-1:0]   addr,
    output logic               wdata_req,
    output logic               cli_wr_done,
    output logic               cli_rd_done,
    output logic               full,
    output logic               empty
);

    localparam int unsigned    ADDR_W    = BANK_W + ROW_W;
    localparam int unsigned    CNT_W     = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    sched_state_t        r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wr_req;
    logic                r_rd_req;
    logic                r_wdata_req;
    logic                r_wr_done;
    logic                r_rd_done;
    logic [BANK_W-1:0]   r_bank;
    logic [ROW_W-1:0]    r_addr;

    logic [ADDR_W:0]     w_wr_ptr;
    logic [ADDR_W:0]     w_rd_ptr;
    logic                w_wr_inc;
    logic                w_rd_inc;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_elig;
    logic                w_rd_elig;
    logic                w_gnt_wr;
    logic                w_gnt_rd;

    // Pointers advance on the last beat of their burst
    assign w_wr_inc = (r_state == ST_WR_BURST) && (r_cnt == C_LAST);
    assign w_rd_inc = (r_state == ST_RD_BURST) && rdata_vld && (r_cnt == C_LAST);

    sdram_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_wr_inc),
        .o_ptr (w_wr_ptr)
    );

    sdram_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_rd_inc),
        .o_ptr (w_rd_ptr)
    );

    // Pointers only move at burst end, so the flags are stable during a burst
    assign w_empty = (w_wr_ptr == w_rd_ptr);
    assign w_full  = (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]) &&
                     (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]);

    assign w_wr_elig = cli_wr_req && !w_full;
    assign w_rd_elig = cli_rd_req && !w_empty;

`ifdef SDRAM_SCHED_RR_EN
    logic r_prio_wr;

    // Remember who was served last; the other client wins the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_wr <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            if (w_gnt_wr) begin
                r_prio_wr <= 1'b0;
            end else if (w_gnt_rd) begin
                r_prio_wr <= 1'b1;
            end
        end
    end

    assign w_gnt_wr = w_wr_elig && (!w_rd_elig || r_prio_wr);
`else
    assign w_gnt_wr = w_wr_elig;
`endif
    assign w_gnt_rd = w_rd_elig && !w_gnt_wr;

    // Scheduler FSM with registered request, address, beat and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wr_req    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_wdata_req <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_bank      <= '0;
            r_addr      <= '0;
        end else begin
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_wr) begin
                        r_state           <= ST_WR_WAIT;
                        r_wr_req          <= 1'b1;
                        {r_bank, r_addr}  <= w_wr_ptr[ADDR_W-1:0];
                    end else if (w_gnt_rd) begin
                        r_state           <= ST_RD_WAIT;
                        r_rd_req          <= 1'b1;
                        {r_bank, r_addr}  <= w_rd_ptr[ADDR_W-1:0];
                    end
                end
                ST_WR_WAIT: begin
                    if (wr_ack) begin
                        r_state     <= ST_WR_BURST;
                        r_wr_req    <= 1'b0;
                        r_wdata_req <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                ST_WR_BURST: begin
                    if (r_cnt == C_LAST) begin
                        r_state     <= ST_IDLE;
                        r_wdata_req <= 1'b0;
                        r_wr_done   <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_ack) begin
                        r_state  <= ST_RD_BURST;
                        r_rd_req <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                ST_RD_BURST: begin
                    // Beats count only on valid read data; gaps are expected
                    if (rdata_vld) begin
                        if (r_cnt == C_LAST) begin
                            r_state   <= ST_IDLE;
                            r_rd_done <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_wr_req    <= 1'b0;
                    r_rd_req    <= 1'b0;
                    r_wdata_req <= 1'b0;
                end
            endcase
        end
    end

    assign wr_req      = r_wr_req;
    assign rd_req      = r_rd_req;
    assign bank        = r_bank;
    assign addr        = r_addr;
    assign wdata_req   = r_wdata_req;
    assign cli_wr_done = r_wr_done;
    assign cli_rd_done = r_rd_done;
    assign full        = w_full;
    assign empty       = w_empty;

endmodule : sdram_burst_sched
`default_nettype wire

// File: tb/tb_sdram_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_burst_sched
// Description : Self-checking bench for sdram_burst_sched with a reduced
//               geometry (16-word bursts, 4 banks x 8 rows). The bench plays
//               the SDRAM interface and predicts grants, addresses and flags
//               from burst totals (occupancy = writes - reads).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_sched;

    localparam int L     = 16;
    localparam int RW    = 3;
    localparam int BW    = 2;
    localparam int ROWS  = 1 << RW;
    localparam int DEPTH = 1 << (RW + BW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cli_wr_req = 1'b0;
    logic          cli_rd_req = 1'b0;
    logic          wr_ack = 1'b0;
    logic          rd_ack = 1'b0;
    logic          rdata_vld = 1'b0;
    logic          wr_req;
    logic          rd_req;
    logic [BW-1:0] bank;
    logic [RW-1:0] addr;
    logic          wdata_req;
    logic          cli_wr_done;
    logic          cli_rd_done;
    logic          full;
    logic          empty;

    sdram_burst_sched #(
        .BURST_LEN (L),
        .ROW_W     (RW),
        .BANK_W    (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cli_wr_req  (cli_wr_req),
        .cli_rd_req  (cli_rd_req),
        .wr_ack      (wr_ack),
        .rd_ack      (rd_ack),
        .rdata_vld   (rdata_vld),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .bank        (bank),
        .addr        (addr),
        .wdata_req   (wdata_req),
        .cli_wr_done (cli_wr_done),
        .cli_rd_done (cli_rd_done),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: burst totals and arbitration memory
    int wr_tot  = 0;
    int rd_tot  = 0;
    bit prio_wr = 1'b1;

    typedef struct packed {
        bit       pre;   // store one burst before applying the vector
        bit       wr;
        bit       rd;
        bit       wack;
        bit       rack;
        bit [1:0] exp;   // 0 none, 1 write grant, 2 read grant
    } vec_t;

    vec_t tbl [10];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        cli_wr_req = 1'b0;
        cli_rd_req = 1'b0;
        wr_ack     = 1'b0;
        rd_ack     = 1'b0;
        rdata_vld  = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        wr_tot  = 0;
        rd_tot  = 0;
        prio_wr = 1'b1;
        tick();
    endtask

    function automatic int exp_grant(input bit w, input bit r);
        int occ;
        bit we;
        bit re;
        occ = wr_tot - rd_tot;
        we  = w && (occ < DEPTH);
        re  = r && (occ > 0);
`ifdef SDRAM_SCHED_RR_EN
        if (we && re) return prio_wr ? 1 : 2;
`endif
        if (we) return 1;
        if (re) return 2;
        return 0;
    endfunction

    task automatic note_grant(input int g);
        if (g == 1) prio_wr = 1'b0;
        if (g == 2) prio_wr = 1'b1;
    endtask

    task automatic check_flags(input string tag);
        chk1({tag, "_empty"}, empty, (wr_tot - rd_tot) == 0);
        chk1({tag, "_full"},  full,  (wr_tot - rd_tot) == DEPTH);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_wr_req"},      wr_req, 1'b0);
        chk1({tag, "_rd_req"},      rd_req, 1'b0);
        chk1({tag, "_wdata_req"},   wdata_req, 1'b0);
        chk1({tag, "_cli_wr_done"}, cli_wr_done, 1'b0);
        chk1({tag, "_cli_rd_done"}, cli_rd_done, 1'b0);
        chk1({tag, "_full"},        full, 1'b0);
        chk1({tag, "_empty"},       empty, 1'b1);
        chkv({tag, "_bank"},        int'(bank), 0);
        chkv({tag, "_addr"},        int'(addr), 0);
    endtask

    task automatic check_grant(input string tag, input int g);
        int idx;
        chk1({tag, "_wr_req"}, wr_req, g == 1);
        chk1({tag, "_rd_req"}, rd_req, g == 2);
        if (g != 0) begin
            idx = ((g == 1) ? wr_tot : rd_tot) % DEPTH;
            chkv({tag, "_bank"}, int'(bank), idx / ROWS);
            chkv({tag, "_addr"}, int'(addr), idx % ROWS);
        end
    endtask

    // Called in the first cycle wr_req is visible; returns in the done cycle
    task automatic serve_write(input int d, input bit stray);
        int idx;
        idx = wr_tot % DEPTH;
        for (int i = 0; i <= d; i++) begin
            chk1("wr_req_wait", wr_req, 1'b1);
            chk1("wdata_req_wait", wdata_req, 1'b0);
            rd_ack = stray;
            wr_ack = (i == d);
            tick();
            wr_ack = 1'b0;
            rd_ack = 1'b0;
        end
        chk1("wr_req_after_ack", wr_req, 1'b0);
        for (int b = 0; b < L; b++) begin
            chk1("wdata_req_beat", wdata_req, 1'b1);
            chk1("wr_done_early", cli_wr_done, 1'b0);
            chkv("wr_bank_hold", int'(bank), idx / ROWS);
            chkv("wr_addr_hold", int'(addr), idx % ROWS);
            tick();
        end
        chk1("wdata_req_end", wdata_req, 1'b0);
        chk1("cli_wr_done", cli_wr_done, 1'b1);
        wr_tot++;
        check_flags("after_wr");
    endtask

    // Called in the first cycle rd_req is visible; returns in the done cycle
    task automatic serve_read(input int d, input bit stray);
        int idx;
        int pulses;
        int guard;
        bit v;
        idx    = rd_tot % DEPTH;
        pulses = 0;
        guard  = 0;
        for (int i = 0; i <= d; i++) begin
            chk1("rd_req_wait", rd_req, 1'b1);
            wr_ack = stray;
            rd_ack = (i == d);
            tick();
            wr_ack = 1'b0;
            rd_ack = 1'b0;
        end
        chk1("rd_req_after_ack", rd_req, 1'b0);
        while (pulses < L && guard < 8 * L) begin
            v = (guard != 0) && ($urandom_range(0, 2) != 0);
            chk1("rd_done_early", cli_rd_done, 1'b0);
            chk1("wdata_req_in_read", wdata_req, 1'b0);
            chkv("rd_bank_hold", int'(bank), idx / ROWS);
            chkv("rd_addr_hold", int'(addr), idx % ROWS);
            rdata_vld = v;
            wr_ack    = stray && ($urandom_range(0, 7) == 0);
            tick();
            rdata_vld = 1'b0;
            wr_ack    = 1'b0;
            if (v) pulses++;
            guard++;
        end
        if (pulses < L) chkv("rd_burst_budget", pulses, L);
        chk1("cli_rd_done", cli_rd_done, 1'b1);
        rd_tot++;
        check_flags("after_rd");
    endtask

    task automatic serve(input int g, input int d, input bit stray);
        if (g == 1) serve_write(d, stray);
        else if (g == 2) serve_read(d, stray);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g;
        int prev_g;
        bit w;
        bit r;

        tbl[0] = '{pre: 1'b0, wr: 1'b0, rd: 1'b0, wack: 1'b0, rack: 1'b0, exp: 2'd0};
        tbl[1] = '{pre: 1'b0, wr: 1'b0, rd: 1'b1, wack: 1'b0, rack: 1'b0, exp: 2'd0};
        tbl[2] = '{pre: 1'b0, wr: 1'b1, rd: 1'b0, wack: 1'b0, rack: 1'b0, exp: 2'd1};
        tbl[3] = '{pre: 1'b0, wr: 1'b1, rd: 1'b1, wack: 1'b0, rack: 1'b0, exp: 2'd1};
        tbl[4] = '{pre: 1'b0, wr: 1'b0, rd: 1'b0, wack: 1'b1, rack: 1'b0, exp: 2'd0};
        tbl[5] = '{pre: 1'b0, wr: 1'b0, rd: 1'b1, wack: 1'b0, rack: 1'b1, exp: 2'd0};
        tbl[6] = '{pre: 1'b1, wr: 1'b0, rd: 1'b1, wack: 1'b0, rack: 1'b0, exp: 2'd2};
`ifdef SDRAM_SCHED_RR_EN
        tbl[7] = '{pre: 1'b1, wr: 1'b1, rd: 1'b1, wack: 1'b0, rack: 1'b0, exp: 2'd2};
`else
        tbl[7] = '{pre: 1'b1, wr: 1'b1, rd: 1'b1, wack: 1'b0, rack: 1'b0, exp: 2'd1};
`endif
        tbl[8] = '{pre: 1'b1, wr: 1'b0, rd: 1'b0, wack: 1'b1, rack: 1'b1, exp: 2'd0};
        tbl[9] = '{pre: 1'b1, wr: 1'b1, rd: 1'b0, wack: 1'b0, rack: 1'b0, exp: 2'd1};

        // Reset state
        do_reset();
        check_reset_outputs("reset");

        // Table-driven single-decision vectors, each from a fresh reset
        for (int k = 0; k < 10; k++) begin
            do_reset();
            if (tbl[k].pre) begin
                cli_wr_req = 1'b1;
                tick();
                check_grant("tbl_pre", 1);
                note_grant(1);
                cli_wr_req = 1'b0;
                serve_write(1, 1'b0);
                tick();
            end
            cli_wr_req = tbl[k].wr;
            cli_rd_req = tbl[k].rd;
            wr_ack     = tbl[k].wack;
            rd_ack     = tbl[k].rack;
            tick();
            cli_wr_req = 1'b0;
            cli_rd_req = 1'b0;
            wr_ack     = 1'b0;
            rd_ack     = 1'b0;
            check_grant($sformatf("tbl%0d", k), int'(tbl[k].exp));
            chk1($sformatf("tbl%0d_wdata_req", k), wdata_req, 1'b0);
            if (tbl[k].exp == 2'd0) begin
                tick();
                check_grant($sformatf("tbl%0d_hold", k), 0);
            end
        end

        // Single write, ack three cycles after the request
        do_reset();
        cli_wr_req = 1'b1;
        tick();
        check_grant("single_wr", 1);
        note_grant(1);
        cli_wr_req = 1'b0;
        serve_write(3, 1'b0);
        tick();
        chk1("wr_done_single_pulse", cli_wr_done, 1'b0);

        // Read back the stored burst with gaps in rdata_vld
        cli_rd_req = 1'b1;
        tick();
        check_grant("rd_after_wr", 2);
        note_grant(2);
        cli_rd_req = 1'b0;
        serve_read(2, 1'b1);
        tick();
        chk1("rd_done_single_pulse", cli_rd_done, 1'b0);
        chk1("empty_after_rd", empty, 1'b1);

        // Read while empty never raises rd_req
        cli_rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("rd_req_when_empty", rd_req, 1'b0);
        end
        cli_rd_req = 1'b0;

        // Reset in the middle of a write burst
        cli_wr_req = 1'b1;
        tick();
        check_grant("abort_wr", 1);
        cli_wr_req = 1'b0;
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk1("abort_beat_active", wdata_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        tick();
        rst_n   = 1'b1;
        wr_tot  = 0;
        rd_tot  = 0;
        prio_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("abort_no_done", cli_wr_done, 1'b0);
            chk1("abort_no_wdata", wdata_req, 1'b0);
            chk1("abort_empty", empty, 1'b1);
        end
        cli_wr_req = 1'b1;
        tick();
        check_grant("post_abort_wr", 1);
        note_grant(1);
        cli_wr_req = 1'b0;
        serve_write(0, 1'b0);

        // Both clients held with one burst stored
        do_reset();
        cli_wr_req = 1'b1;
        tick();
        check_grant("alt_pre", 1);
        note_grant(1);
        cli_wr_req = 1'b0;
        serve_write(1, 1'b0);
        cli_wr_req = 1'b1;
        cli_rd_req = 1'b1;
        prev_g = 1;
        for (int k = 0; k < 4; k++) begin
            g = exp_grant(1'b1, 1'b1);
            tick();
            check_grant($sformatf("alt%0d", k), g);
`ifdef SDRAM_SCHED_RR_EN
            chk1($sformatf("alt%0d_alternates", k), wr_req, prev_g == 2);
`else
            chk1($sformatf("alt%0d_write_first", k), wr_req, 1'b1);
`endif
            note_grant(g);
            prev_g = g;
            serve(g, $urandom_range(0, 2), 1'b0);
        end
        cli_wr_req = 1'b0;
        cli_rd_req = 1'b0;
        tick();

        // Fill every slot with writes only
        do_reset();
        cli_wr_req = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            check_grant("fill", 1);
            if (k == DEPTH - 1) begin
                chkv("fill_last_bank", int'(bank), (1 << BW) - 1);
                chkv("fill_last_row", int'(addr), ROWS - 1);
            end
            note_grant(1);
            serve_write(0, 1'b0);
        end
        chk1("fill_full", full, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("no_wr_when_full", wr_req, 1'b0);
            chk1("full_held", full, 1'b1);
        end
        cli_rd_req = 1'b1;
        g = exp_grant(1'b1, 1'b1);
        tick();
        check_grant("rd_when_full", g);
        note_grant(g);
        cli_wr_req = 1'b0;
        cli_rd_req = 1'b0;
        serve(g, 1, 1'b1);
        tick();

        // Randomized traffic against the occupancy model
        do_reset();
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            g = exp_grant(w, r);
            cli_wr_req = w;
            cli_rd_req = r;
            tick();
            cli_wr_req = 1'b0;
            cli_rd_req = 1'b0;
            check_grant($sformatf("rand%0d", n), g);
            note_grant(g);
            serve(g, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            tick();
            chk1("rand_wr_done_idle", cli_wr_done, 1'b0);
            chk1("rand_rd_done_idle", cli_rd_done, 1'b0);
            check_flags("rand_idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sdram_burst_sched
`default_nettype wire
